// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register: drives a req/ack data bus,
// steers RV32 byte/half/word lanes, and stalls upstream while an access is outstanding.
module mem_wb_stage #(
   parameter int REG_NUM_BITWIDTH = 5,
   parameter int WORD_BITWIDTH    = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        mem_memToReg,
   input  logic                        mem_memRead,
   input  logic                        mem_memWrite,
   input  logic [WORD_BITWIDTH-1:0]    mem_ALUresult,
   input  logic [WORD_BITWIDTH-1:0]    mem_finalReadData2,
   input  logic [2:0]                  mem_funct3,
   input  logic                        mem_wt_regWrite,
   input  logic [REG_NUM_BITWIDTH-1:0] mem_wt_regToWrite,
   output logic                        dmem_req,
   output logic                        dmem_we,
   output logic [WORD_BITWIDTH-1:0]    dmem_addr,
   output logic [WORD_BITWIDTH-1:0]    dmem_wdata,
   output logic [3:0]                  dmem_be,
   input  logic [WORD_BITWIDTH-1:0]    dmem_rdata,
   input  logic                        dmem_ack,
   output logic                        memStall,
   output logic                        wb_regWrite,
   output logic [REG_NUM_BITWIDTH-1:0] wb_regToWrite,
   output logic [WORD_BITWIDTH-1:0]    wb_writeData,
   output logic                        misaligned
);
   localparam int W = WORD_BITWIDTH;
   localparam int R = REG_NUM_BITWIDTH;

   typedef enum logic {IDLE, ACCESS} state_e;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

   // Undefined funct3 encodings fall back to a full-word access.
   function automatic size_e decode_size(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: decode_size = SZ_B;
         3'b001, 3'b101: decode_size = SZ_H;
         default:        decode_size = SZ_W;
      endcase
   endfunction

   state_e         state_q, state_d;
   logic           dmem_we_q, dmem_we_d;
   logic [W-1:0]   dmem_addr_q, dmem_addr_d;
   logic [W-1:0]   dmem_wdata_q, dmem_wdata_d;
   logic [3:0]     dmem_be_q, dmem_be_d;
   logic           mem_to_reg_q, mem_to_reg_d;
   logic           load_q, load_d;
   size_e          size_q, size_d;
   logic           sext_q, sext_d;
   logic [1:0]     off_q, off_d;
   logic [W-1:0]   alu_q, alu_d;
   logic           reg_write_q, reg_write_d;
   logic [R-1:0]   reg_to_write_q, reg_to_write_d;
   logic           wb_reg_write_q, wb_reg_write_d;
   logic [R-1:0]   wb_reg_to_write_q, wb_reg_to_write_d;
   logic [W-1:0]   wb_write_data_q, wb_write_data_d;
   logic           misaligned_q, misaligned_d;
   logic           stall;

   logic           access_in, aligned_in, reg_write_in;
   size_e          size_in;
   logic [1:0]     off_in;
   logic [3:0]     be_st;
   logic [W-1:0]   wdata_st;
   logic [7:0]     ld_byte;
   logic [15:0]    ld_half;
   logic [W-1:0]   load_fmt;

   assign access_in    = mem_memRead | mem_memWrite;
   assign size_in      = decode_size(mem_funct3);
   assign off_in       = mem_ALUresult[1:0];
   assign reg_write_in = mem_wt_regWrite && (mem_wt_regToWrite != '0);

   // NOTE: every signal assigned in an always_comb gets a default first so no latch is inferred.
   always_comb begin
      aligned_in = 1'b1;
      be_st      = 4'b1111;
      wdata_st   = mem_finalReadData2;
      case (size_in)
         SZ_B: begin
            be_st    = 4'b0001 << off_in;
            wdata_st = {4{mem_finalReadData2[7:0]}};
         end
         SZ_H: begin
            aligned_in = ~off_in[0];
            be_st      = 4'b0011 << off_in;
            wdata_st   = {2{mem_finalReadData2[15:0]}};
         end
         default: aligned_in = (off_in == 2'b00);
      endcase
   end

   // Load formatting works from the offset/size latched when the access was issued.
   always_comb begin
      ld_byte  = dmem_rdata[{off_q, 3'b000} +: 8];
      ld_half  = dmem_rdata[{off_q[1], 4'b0000} +: 16];
      load_fmt = dmem_rdata;
      case (size_q)
         SZ_B:    load_fmt = sext_q ? {{(W-8){ld_byte[7]}}, ld_byte} : {{(W-8){1'b0}}, ld_byte};
         SZ_H:    load_fmt = sext_q ? {{(W-16){ld_half[15]}}, ld_half} : {{(W-16){1'b0}}, ld_half};
         default: load_fmt = dmem_rdata;
      endcase
   end

   always_comb begin
      state_d           = state_q;
      dmem_we_d         = dmem_we_q;
      dmem_addr_d       = dmem_addr_q;
      dmem_wdata_d      = dmem_wdata_q;
      dmem_be_d         = dmem_be_q;
      mem_to_reg_d      = mem_to_reg_q;
      load_d            = load_q;
      size_d            = size_q;
      sext_d            = sext_q;
      off_d             = off_q;
      alu_d             = alu_q;
      reg_write_d       = reg_write_q;
      reg_to_write_d    = reg_to_write_q;
      wb_reg_write_d    = 1'b0;
      wb_reg_to_write_d = wb_reg_to_write_q;
      wb_write_data_d   = wb_write_data_q;
      misaligned_d      = 1'b0;
      stall             = 1'b0;
      case (state_q)
         IDLE: begin
            if (!access_in) begin
               wb_reg_write_d    = reg_write_in;
               wb_reg_to_write_d = mem_wt_regToWrite;
               wb_write_data_d   = mem_ALUresult;
            end else if (!aligned_in) begin
               misaligned_d      = 1'b1;
               wb_reg_to_write_d = mem_wt_regToWrite;
               wb_write_data_d   = mem_ALUresult;
            end else begin
               stall          = 1'b1;
               state_d        = ACCESS;
               dmem_we_d      = mem_memWrite;
               dmem_addr_d    = {mem_ALUresult[W-1:2], 2'b00};
               dmem_wdata_d   = mem_memWrite ? wdata_st : '0;
               dmem_be_d      = mem_memWrite ? be_st : 4'b0000;
               mem_to_reg_d   = mem_memToReg;
               load_d         = ~mem_memWrite;
               size_d         = size_in;
               sext_d         = ~mem_funct3[2];
               off_d          = off_in;
               alu_d          = mem_ALUresult;
               reg_write_d    = reg_write_in;
               reg_to_write_d = mem_wt_regToWrite;
            end
         end
         ACCESS: begin
            stall = ~dmem_ack;
            if (dmem_ack) begin
               state_d           = IDLE;
               wb_reg_write_d    = reg_write_q;
               wb_reg_to_write_d = reg_to_write_q;
               wb_write_data_d   = (mem_to_reg_q && load_q) ? load_fmt : alu_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q           <= IDLE;
         dmem_we_q         <= 1'b0;
         dmem_addr_q       <= '0;
         dmem_wdata_q      <= '0;
         dmem_be_q         <= 4'b0000;
         mem_to_reg_q      <= 1'b0;
         load_q            <= 1'b0;
         size_q            <= SZ_B;
         sext_q            <= 1'b0;
         off_q             <= 2'b00;
         alu_q             <= '0;
         reg_write_q       <= 1'b0;
         reg_to_write_q    <= '0;
         wb_reg_write_q    <= 1'b0;
         wb_reg_to_write_q <= '0;
         wb_write_data_q   <= '0;
         misaligned_q      <= 1'b0;
      end else begin
         state_q           <= state_d;
         dmem_we_q         <= dmem_we_d;
         dmem_addr_q       <= dmem_addr_d;
         dmem_wdata_q      <= dmem_wdata_d;
         dmem_be_q         <= dmem_be_d;
         mem_to_reg_q      <= mem_to_reg_d;
         load_q            <= load_d;
         size_q            <= size_d;
         sext_q            <= sext_d;
         off_q             <= off_d;
         alu_q             <= alu_d;
         reg_write_q       <= reg_write_d;
         reg_to_write_q    <= reg_to_write_d;
         wb_reg_write_q    <= wb_reg_write_d;
         wb_reg_to_write_q <= wb_reg_to_write_d;
         wb_write_data_q   <= wb_write_data_d;
         misaligned_q      <= misaligned_d;
      end
   end

   assign dmem_req      = (state_q == ACCESS);
   assign dmem_we       = dmem_we_q;
   assign dmem_addr     = dmem_addr_q;
   assign dmem_wdata    = dmem_wdata_q;
   assign dmem_be       = dmem_be_q;
   // NOTE: the stall is combinational, so reset must mask it directly to drop it at once.
   assign memStall      = stall & ~rst;
   assign wb_regWrite   = wb_reg_write_q;
   assign wb_regToWrite = wb_reg_to_write_q;
   assign wb_writeData  = wb_write_data_q;
   assign misaligned    = misaligned_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: random and directed instructions, a latency-randomised
// bus slave, and a monitor comparing bus requests, write-backs and misaligned pulses.
module tb_mem_wb_stage;
   localparam int R = 5;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         mem_memToReg, mem_memRead, mem_memWrite;
   logic [W-1:0] mem_ALUresult, mem_finalReadData2;
   logic [2:0]   mem_funct3;
   logic         mem_wt_regWrite;
   logic [R-1:0] mem_wt_regToWrite;
   logic         dmem_req, dmem_we;
   logic [W-1:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]   dmem_be;
   logic         dmem_ack;
   logic         memStall, wb_regWrite, misaligned;
   logic [R-1:0] wb_regToWrite;
   logic [W-1:0] wb_writeData;

   mem_wb_stage #(.REG_NUM_BITWIDTH(R), .WORD_BITWIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .mem_memToReg(mem_memToReg), .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
      .mem_ALUresult(mem_ALUresult), .mem_finalReadData2(mem_finalReadData2),
      .mem_funct3(mem_funct3), .mem_wt_regWrite(mem_wt_regWrite),
      .mem_wt_regToWrite(mem_wt_regToWrite),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
      .dmem_ack(dmem_ack), .memStall(memStall), .wb_regWrite(wb_regWrite),
      .wb_regToWrite(wb_regToWrite), .wb_writeData(wb_writeData), .misaligned(misaligned)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         rd_en, wr_en, m2r, rw;
      logic [2:0]   f3;
      logic [31:0]  alu, sdata, rdata;
      logic [4:0]   rd;
   } instr_t;
   typedef struct { logic [4:0] rd; logic [31:0] data; int cyc; } wb_exp_t;
   typedef struct { logic we; logic [31:0] addr, wdata; logic [3:0] be; int cyc; } bus_exp_t;

   wb_exp_t  wb_q[$];
   bus_exp_t bus_q[$];
   int       mis_q[$];
   int       n_checks = 0;
   int       n_pass = 0;
   int       cyc = 0;
   int       cur_lat = 0;
   logic [31:0] cur_rdata = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic fail_now(input string name, input string what);
      n_checks++;
      $display("FAIL %s: %s", name, what);
   endtask

   // Reference model: access width in bytes, signedness, alignment and lane contents.
   function automatic int size_of(input logic [2:0] f3);
      if (f3 == 3'b000 || f3 == 3'b100) return 1;
      if (f3 == 3'b001 || f3 == 3'b101) return 2;
      return 4;
   endfunction

   function automatic logic is_aligned(input logic [2:0] f3, input logic [31:0] a);
      return (int'(a[1:0]) % size_of(f3)) == 0;
   endfunction

   function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rdata);
      int sz = size_of(f3);
      int off = int'(a[1:0]);
      logic [31:0] v = '0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = rdata[8*(off+i) +: 8];
      if (sz < 4 && (f3 == 3'b000 || f3 == 3'b001) && v[8*sz-1])
         for (int b = 8*sz; b < 32; b++) v[b] = 1'b1;
      return v;
   endfunction

   function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [31:0] a);
      int sz = size_of(f3);
      int off = int'(a[1:0]);
      logic [3:0] be = '0;
      for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + sz);
      return be;
   endfunction

   function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
      int sz = size_of(f3);
      logic [31:0] w = '0;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
      return w;
   endfunction

   // Bus slave: acks the access cur_lat cycles after dmem_req rises; ignored acks while idle.
   initial begin
      int req_cycles = 0;
      dmem_ack = 1'b0;
      dmem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (dmem_req) begin
            dmem_ack = (req_cycles == cur_lat);
            dmem_rdata = dmem_ack ? cur_rdata : $urandom();
            req_cycles++;
         end else begin
            req_cycles = 0;
            dmem_ack = ($urandom_range(0, 4) == 0);
            dmem_rdata = $urandom();
         end
      end
   end

   // Monitor: compares whatever the DUT presents against the queued expectations.
   initial begin
      logic     req_prev = 1'b0;
      bus_exp_t snap;
      wb_exp_t  we;
      forever begin
         @(negedge clk);
         if (dmem_req && !req_prev) begin
            if (bus_q.size() == 0) fail_now("unexpected_req", "got dmem_req rise, expected none");
            else begin
               snap = bus_q.pop_front();
               check("bus_cycle", 32'(cyc), 32'(snap.cyc));
               check("bus_we", 32'(dmem_we), 32'(snap.we));
               check("bus_addr", dmem_addr, snap.addr);
               check("bus_be", 32'(dmem_be), 32'(snap.be));
               if (snap.we) check("bus_wdata", dmem_wdata, snap.wdata);
            end
            snap.addr = dmem_addr;
            snap.wdata = dmem_wdata;
            snap.be = dmem_be;
            snap.we = dmem_we;
         end else if (dmem_req) begin
            check("bus_stable_addr", dmem_addr, snap.addr);
            check("bus_stable_wdata", dmem_wdata, snap.wdata);
            check("bus_stable_ctl", 32'({dmem_we, dmem_be}), 32'({snap.we, snap.be}));
         end
         req_prev = dmem_req;
         if (wb_regWrite) begin
            if (wb_q.size() == 0) fail_now("unexpected_wb", "got wb_regWrite=1, expected 0");
            else begin
               we = wb_q.pop_front();
               check("wb_cycle", 32'(cyc), 32'(we.cyc));
               check("wb_rd", 32'(wb_regToWrite), 32'(we.rd));
               check("wb_data", wb_writeData, we.data);
            end
         end
         if (misaligned) begin
            if (mis_q.size() == 0) fail_now("unexpected_misaligned", "got misaligned=1, expected 0");
            else check("misaligned_cycle", 32'(cyc), 32'(mis_q.pop_front()));
         end
      end
   end

   task automatic drive(input instr_t t);
      mem_memRead        = t.rd_en;
      mem_memWrite       = t.wr_en;
      mem_memToReg       = t.m2r;
      mem_funct3         = t.f3;
      mem_ALUresult      = t.alu;
      mem_finalReadData2 = t.sdata;
      mem_wt_regWrite    = t.rw;
      mem_wt_regToWrite  = t.rd;
   endtask

   // Called at posedge+1; presents t, waits for it to be consumed, returns at posedge+1.
   task automatic run_instr(input instr_t t, input int lat);
      logic acc, al, ld;
      int   stalls = 0;
      acc = t.rd_en | t.wr_en;
      al  = is_aligned(t.f3, t.alu);
      ld  = t.rd_en && !t.wr_en;
      drive(t);
      cur_lat = lat;
      cur_rdata = t.rdata;
      @(negedge clk);
      if (acc && al)
         bus_q.push_back('{we: t.wr_en, addr: {t.alu[31:2], 2'b00},
                           wdata: t.wr_en ? store_wdata(t.f3, t.sdata) : 32'h0,
                           be: t.wr_en ? store_be(t.f3, t.alu) : 4'b0000, cyc: cyc + 1});
      while (memStall === 1'b1 && stalls < 40) begin
         stalls++;
         @(negedge clk);
      end
      if (stalls >= 40) fail_now("stall_timeout", "got memStall stuck, expected release");
      check("stall_cycles", 32'(stalls), (acc && al) ? 32'(1 + lat) : 32'h0);
      if (acc && !al) mis_q.push_back(cyc + 1);
      if (t.rw && t.rd != 5'd0 && !(acc && !al))
         wb_q.push_back('{rd: t.rd,
                          data: (ld && t.m2r) ? load_val(t.f3, t.alu, t.rdata) : t.alu,
                          cyc: cyc + 1});
      @(posedge clk);
      #1;
   endtask

   function automatic instr_t rand_instr();
      instr_t t;
      int k = $urandom_range(0, 9);
      t.rd_en = (k >= 3 && k <= 6) || k == 9;
      t.wr_en = (k >= 7);
      t.m2r   = ($urandom_range(0, 3) != 0);
      t.f3    = 3'($urandom_range(0, 7));
      t.alu   = $urandom();
      if ($urandom_range(0, 1) == 1) t.alu[1:0] = 2'b00;
      t.sdata = $urandom();
      t.rdata = $urandom();
      t.rw    = ($urandom_range(0, 3) != 0);
      t.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      return t;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      instr_t t;
      rst = 1'b1;
      t = '{rd_en: 1'b1, wr_en: 1'b0, m2r: 1'b1, rw: 1'b1, f3: 3'b010,
            alu: 32'h0, sdata: 32'h0, rdata: 32'h0, rd: 5'd1};
      drive(t);
      repeat (2) @(negedge clk);
      check("rst_req", 32'(dmem_req), 32'h0);
      check("rst_we", 32'(dmem_we), 32'h0);
      check("rst_addr", dmem_addr, 32'h0);
      check("rst_wdata", dmem_wdata, 32'h0);
      check("rst_be", 32'(dmem_be), 32'h0);
      check("rst_stall", 32'(memStall), 32'h0);
      check("rst_wb_rw", 32'(wb_regWrite), 32'h0);
      check("rst_wb_rd", 32'(wb_regToWrite), 32'h0);
      check("rst_wb_data", wb_writeData, 32'h0);
      check("rst_misaligned", 32'(misaligned), 32'h0);
      t.rd_en = 1'b0;
      drive(t);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // ALU op
      run_instr('{rd_en: 0, wr_en: 0, m2r: 0, rw: 1, f3: 3'b000, alu: 32'h1234,
                  sdata: 32'h0, rdata: 32'h0, rd: 5'd5}, 0);
      check("alu_wb_rw", 32'(wb_regWrite), 32'h1);
      check("alu_wb_rd", 32'(wb_regToWrite), 32'h5);
      check("alu_wb_data", wb_writeData, 32'h1234);
      // LB with sign extension, ack after 3 wait cycles
      run_instr('{rd_en: 1, wr_en: 0, m2r: 1, rw: 1, f3: 3'b000, alu: 32'h1003,
                  sdata: 32'h0, rdata: 32'h80FF_FF7F, rd: 5'd7}, 3);
      check("lb_addr", dmem_addr, 32'h1000);
      check("lb_wb_data", wb_writeData, 32'hFFFF_FF80);
      // LHU, minimum latency
      run_instr('{rd_en: 1, wr_en: 0, m2r: 1, rw: 1, f3: 3'b101, alu: 32'h2002,
                  sdata: 32'h0, rdata: 32'hBEEF_0000, rd: 5'd8}, 0);
      check("lhu_wb_data", wb_writeData, 32'h0000_BEEF);
      // SB
      run_instr('{rd_en: 0, wr_en: 1, m2r: 0, rw: 0, f3: 3'b000, alu: 32'h3001,
                  sdata: 32'h0000_00AB, rdata: 32'h0, rd: 5'd0}, 1);
      check("sb_be", 32'(dmem_be), 32'h2);
      check("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
      check("sb_we", 32'(dmem_we), 32'h1);
      check("sb_wb_rw", 32'(wb_regWrite), 32'h0);
      // Misaligned LW
      run_instr('{rd_en: 1, wr_en: 0, m2r: 1, rw: 1, f3: 3'b010, alu: 32'h4002,
                  sdata: 32'h0, rdata: 32'h0, rd: 5'd9}, 0);
      check("mis_pulse", 32'(misaligned), 32'h1);
      check("mis_wb_rw", 32'(wb_regWrite), 32'h0);

      // Reset while an access is outstanding
      t = '{rd_en: 1, wr_en: 0, m2r: 1, rw: 1, f3: 3'b010, alu: 32'h5000,
            sdata: 32'h0, rdata: 32'h0, rd: 5'd3};
      drive(t);
      cur_lat = 1000;
      @(negedge clk);
      bus_q.push_back('{we: 1'b0, addr: 32'h5000, wdata: 32'h0, be: 4'b0000, cyc: cyc + 1});
      repeat (2) @(negedge clk);
      check("pre_rst_req", 32'(dmem_req), 32'h1);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_req", 32'(dmem_req), 32'h0);
      check("rst_mid_stall", 32'(memStall), 32'h0);
      t.rd_en = 1'b0;
      drive(t);
      @(posedge clk);
      #1;
      rst = 1'b0;
      run_instr('{rd_en: 0, wr_en: 0, m2r: 0, rw: 1, f3: 3'b000, alu: 32'hCAFE_0001,
                  sdata: 32'h0, rdata: 32'h0, rd: 5'd12}, 0);
      check("post_rst_wb_data", wb_writeData, 32'hCAFE_0001);

      for (int n = 0; n < 250; n++) run_instr(rand_instr(), $urandom_range(0, 4));

      t = '{rd_en: 0, wr_en: 0, m2r: 0, rw: 0, f3: 3'b000, alu: 32'h0,
            sdata: 32'h0, rdata: 32'h0, rd: 5'd0};
      drive(t);
      repeat (4) @(negedge clk);
      check("wb_queue_drained", 32'(wb_q.size()), 32'h0);
      check("bus_queue_drained", 32'(bus_q.size()), 32'h0);
      check("mis_queue_drained", 32'(mis_q.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register; consumes the EX/MEM register outputs and produces the write-back bundle for the register file. Drives a variable-latency data-memory bus with a req/ack handshake. Holds the pipeline through `memStall` while an access is outstanding. Performs RV32 byte/half/word lane steering, sign/zero extension and misalignment detection.

## Interface
- `REG_NUM_BITWIDTH`, default 5: register index width.
- `WORD_BITWIDTH`, default 32: data/address width. Only 32 is supported, because byte-lane logic assumes 4 lanes.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_memToReg` in 1: write-back selects load data, else ALU result.
- `mem_memRead` in 1: load request.
- `mem_memWrite` in 1: store request.
- `mem_ALUresult` in W: effective address / ALU result.
- `mem_finalReadData2` in W: store data.
- `mem_funct3` in 3: access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `mem_wt_regWrite` in 1: destination write enable.
- `mem_wt_regToWrite` in R: destination register.
- `dmem_req` out 1: bus request.
- `dmem_we` out 1: 1 = store.
- `dmem_addr` out W: word address, with `{ALUresult[W-1:2],2'b00}`.
- `dmem_wdata` out W: lane-replicated store data.
- `dmem_be` out 4: byte enables, all zero for loads.
- `dmem_rdata` in W: read word, valid when `dmem_ack`=1.
- `dmem_ack` in 1: access complete, one-cycle pulse.
- `memStall` out 1: upstream must hold EX/MEM contents.
- `wb_regWrite` out 1, `wb_regToWrite` out R, `wb_writeData` out W: MEM/WB register.
- `misaligned` out 1: registered one-cycle pulse on a misaligned access.

## Operation
- **FSM states:** IDLE, ACCESS.
- **access** = `memRead|memWrite`. **aligned** holds as follows:
  - H/HU: `addr[0]==0`.
  - W: `addr[1:0]==0`.
  - B/BU: always.
- **IDLE with no access:** MEM/WB captures the inputs every cycle. `wb_writeData` = ALUresult.
- **IDLE with an aligned access:** `memStall`=1 combinationally. Go to ACCESS. Latch `dmem_we`, `dmem_addr`, `dmem_wdata`, `dmem_be` from the current inputs. MEM/WB captures a bubble (`wb_regWrite`=0).
- **ACCESS:**
  - `dmem_req`=1 and all bus outputs stay stable until ack.
  - `memStall` = `!dmem_ack`.
  - On ack: MEM/WB captures the instruction, with `wb_writeData` = formatted load data if `memToReg`, else ALUresult. Then go to IDLE.
  - Without ack: MEM/WB holds a bubble.
- **Store lanes:**
  - SB: `be` = `1<<addr[1:0]`, wdata = byte×4.
  - SH: `be` = `4'b0011<<addr[1:0]`, wdata = half×2.
  - SW: `be` = `4'b1111`.
- **Load format:** select byte/half by `addr[1:0]`. Sign-extend for B/H, zero-extend for BU/HU. LW passes the word through.
- **Misaligned access:** no bus transaction and no stall. MEM/WB captures with `wb_regWrite`=0. `misaligned`=1 for the next cycle.
- **Read and write both set:** treated as a store only. Write-back data is ALUresult.
- `wb_regWrite` is forced 0 when `regToWrite`==0 (x0).
- `dmem_ack` while in IDLE is ignored.
- An undefined funct3 with access set is treated as W.

## Timing
- **Reset values:** state IDLE. `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `dmem_be`, `memStall`, `wb_*` and `misaligned` are all 0.
- **Reset mid-access:** the request is dropped immediately (async). The bus slave must tolerate an abandoned request.
- **Non-memory instruction:** one cycle in the stage.
- **Memory access:** 1 + N cycles, where N ≥ 1 is the number of cycles from `dmem_req` rising to the sampled ack. `dmem_req` rises the cycle after the access is presented.
- **Ack timing:** an ack in the same cycle as the first `dmem_req` gives the minimum 2-cycle access.
- **Back-to-back accesses:** the next access is presented the cycle after ack. IDLE handles it immediately, with no dead cycle beyond the IDLE→ACCESS cycle.
- **Held inputs:** EX/MEM inputs are sampled only in IDLE. Inputs change while in ACCESS is a protocol violation by the upstream stage, and the latched values govern.

## Test plan
- **ALU op:** regWrite=1, rd=5, ALUresult=0x1234, no access → next edge `wb_regWrite`=1, `wb_regToWrite`=5, `wb_writeData`=0x1234. `dmem_req` never rises.
- **LB sign extension:** ALUresult=0x1003, funct3=000, rdata=0x80FF_FF7F, ack after 3 cycles → stall high for 4 cycles. `dmem_addr`=0x1000, `wb_writeData`=0xFFFF_FF80.
- **LHU:** addr 0x2002, rdata=0xBEEF_0000 → `wb_writeData`=0x0000_BEEF.
- **SB:** addr 0x3001, data 0x0000_00AB → `dmem_be`=0010, `dmem_wdata`=0xABAB_ABAB, `dmem_we`=1, `wb_regWrite`=0.
- **Misaligned LW:** addr 0x4002 → no `dmem_req`, no stall, `misaligned` pulse of 1 cycle, `wb_regWrite`=0.
- **Reset during ACCESS:** assert `rst` before ack → `dmem_req`=0 and `memStall`=0 at once. After release, an ALU op completes normally.
